// File: rtl/mystery_mux_if.sv
// Data bundle for the mystery_mux selector: two data inputs, the select and
// the steered output.
interface mystery_mux_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] x1;
    logic             s;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] f;

    modport master (
        output x1,
        output s,
        output x2,
        input  f
    );

    modport slave (
        input  x1,
        input  s,
        input  x2,
        output f
    );
endinterface

// File: rtl/mystery_mux.sv
// Registered 2:1 bitwise selector: f = s ? x2 : x1, delayed by PIPE_STAGES clocks
// through a plain shift chain that clears synchronously on rst.
module mystery_mux #(
    parameter int WIDTH       = 1,
    parameter int PIPE_STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    mystery_mux_if.slave  bus
);

    logic [WIDTH-1:0] sel_d;

    always_comb begin
        sel_d = bus.s ? bus.x2 : bus.x1;
    end

    generate
        if (PIPE_STAGES == 0) begin : g_comb
            // Purely combinational: clk and rst intentionally have no effect.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign bus.f = sel_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_q [PIPE_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_STAGES; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= sel_d;
                    for (int i = 1; i < PIPE_STAGES; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign bus.f = pipe_q[PIPE_STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_mystery_mux.sv
// Scoreboard bench for mystery_mux: 1-bit/1-stage, 8-bit/3-stage and
// 4-bit/combinational instances driven with hand-computed directed vectors.
module tb_mystery_mux;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;

    int checks = 0;
    int errors = 0;

    mystery_mux_if #(.WIDTH(1)) bus_a ();
    mystery_mux_if #(.WIDTH(8)) bus_b ();
    mystery_mux_if #(.WIDTH(4)) bus_c ();

    mystery_mux #(.WIDTH(1), .PIPE_STAGES(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    mystery_mux #(.WIDTH(8), .PIPE_STAGES(3)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
    mystery_mux #(.WIDTH(4), .PIPE_STAGES(0)) dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

    logic [0:0] q_a [$];
    logic [7:0] q_b [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // Monitors: each output sample after an edge is matched to the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            logic [0:0] exp_a;
            exp_a = q_a.pop_front();
            checks++;
            if (bus_a.f !== exp_a) begin
                errors++;
                $display("FAIL dut_a f @%0t: got %b want %b", $time, bus_a.f, exp_a);
            end
        end
        if (q_b.size() > 0) begin
            logic [7:0] exp_b;
            exp_b = q_b.pop_front();
            checks++;
            if (bus_b.f !== exp_b) begin
                errors++;
                $display("FAIL dut_b f @%0t: got %h want %h", $time, bus_b.f, exp_b);
            end
        end
    end

    task automatic drive_a(input logic r, input logic x1, input logic s, input logic x2,
                           input logic exp_f);
        @(negedge clk);
        rst_a    = r;
        bus_a.x1 = x1;
        bus_a.s  = s;
        bus_a.x2 = x2;
        q_a.push_back(exp_f);
    endtask

    task automatic drive_b(input logic r, input logic [7:0] x1, input logic s,
                           input logic [7:0] x2, input logic [7:0] exp_f);
        @(negedge clk);
        rst_b    = r;
        bus_b.x1 = x1;
        bus_b.s  = s;
        bus_b.x2 = x2;
        q_b.push_back(exp_f);
    endtask

    task automatic check_c(input string name, input logic [3:0] exp_f);
        #1;
        checks++;
        if (bus_c.f !== exp_f) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, bus_c.f, exp_f);
        end
    endtask

    task automatic run_a();
        logic [2:0] tt_in  [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                   3'b100, 3'b101, 3'b110, 3'b111};
        logic       tt_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = tt_in[i];
            drive_a(1'b0, v[2], v[1], v[0], tt_exp[i]);
        end
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b0, 1'b0, i[0], 1'b1, i[0]);
        end
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic run_b();
        drive_b(1'b1, 8'hA5, 1'b0, 8'h3C, 8'h00);
        drive_b(1'b1, 8'hA5, 1'b0, 8'h3C, 8'h00);
        drive_b(1'b0, 8'hA5, 1'b0, 8'h3C, 8'h00);
        drive_b(1'b0, 8'hA5, 1'b1, 8'h3C, 8'h00);
        drive_b(1'b0, 8'hA5, 1'b1, 8'h3C, 8'hA5);
        drive_b(1'b0, 8'hA5, 1'b1, 8'h3C, 8'h3C);
        // Reset discards whatever is still in flight.
        drive_b(1'b1, 8'hA5, 1'b1, 8'h3C, 8'h00);
        drive_b(1'b0, 8'hF0, 1'b1, 8'h0F, 8'h00);
        drive_b(1'b0, 8'hF0, 1'b0, 8'h0F, 8'h00);
        drive_b(1'b0, 8'hF0, 1'b1, 8'h0F, 8'h0F);
        drive_b(1'b0, 8'hF0, 1'b0, 8'h0F, 8'hF0);
        drive_b(1'b0, 8'hF0, 1'b0, 8'h0F, 8'h0F);
        drive_b(1'b0, 8'hF0, 1'b0, 8'h0F, 8'hF0);
    endtask

    task automatic run_c();
        @(negedge clk);
        #2;
        rst_c = 1'b0;
        bus_c.x1 = 4'hA;
        bus_c.x2 = 4'h5;
        bus_c.s  = 1'b0;
        check_c("comb s0", 4'hA);
        bus_c.s = 1'b1;
        check_c("comb s1", 4'h5);
        bus_c.x2 = 4'h3;
        check_c("comb x2 change", 4'h3);
        rst_c = 1'b1;
        check_c("comb rst ignored", 4'h3);
        bus_c.s = 1'b0;
        check_c("comb s0 under rst", 4'hA);
        @(posedge clk);
        check_c("comb after edge", 4'hA);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        bus_a.x1 = 1'b0; bus_a.s = 1'b0; bus_a.x2 = 1'b0;
        bus_b.x1 = 8'h00; bus_b.s = 1'b0; bus_b.x2 = 8'h00;
        bus_c.x1 = 4'h0; bus_c.s = 1'b0; bus_c.x2 = 4'h0;
        fork
            run_a();
            run_b();
            run_c();
        join
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL dut_a drain: got %0d pending want 0", q_a.size());
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL dut_b drain: got %0d pending want 0", q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mystery_mux.md
Name: mystery_mux

Overview:
- Registered 2:1 selector: output f follows x1 when s=0 and x2 when s=1, i.e. f = (~s & x1) | (s & x2).
- Used as a basic steering element in lab datapaths.
- Data width and pipeline depth are parameterized.
- Defaults give a 1-bit mux with one register stage.

Parameters:
- WIDTH, 1, bit width of x1, x2 and f.
- PIPE_STAGES, 1, number of register stages between the inputs and f. Legal range is 0..8. A value of 0 gives a purely combinational path: clk and rst are unused and there is no reset value.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  synchronous, active-high reset.
- x1  input  WIDTH  data input selected when s=0.
- s  input  1  select: 0 selects x1, 1 selects x2.
- x2  input  WIDTH  data input selected when s=1.
- f  output  WIDTH  selected data, delayed by PIPE_STAGES clocks.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Selection is bitwise: f[i] = s ? x2[i] : x1[i]. The select is a single bit shared by all data bits. No arithmetic and no width change.
- Select decode: s is treated strictly as 0 or 1. X/Z on s is not a supported input.
- Latency: f at cycle n+PIPE_STAGES equals the selection computed from x1, s, x2 sampled at edge n.
  - With PIPE_STAGES=1: inputs are captured at a rising edge and f updates just after that edge.
- Throughput: one new selection per clock. No stall, handshake or enable.
- Reset: while rst=1 at a rising edge, every pipeline register is cleared to 0, so f=0 after that edge.
  - Data inside the pipeline when reset is asserted is discarded.
  - Reset holds as long as rst stays high.
- Release from reset:
  - The first edge with rst=0 captures the current inputs.
  - f shows that value PIPE_STAGES edges later.
  - Stages not yet refilled present 0.
- Input timing: inputs may change at any time between edges. Only values at the rising edge matter.
- Glitch-free output: f changes only at clock edges when PIPE_STAGES>=1.
- Pipeline structure: registers form a simple shift chain of WIDTH-bit stages. No bypass, no gating.
- Power-up (before any reset): f is undefined. Verification must apply reset first.
- Simultaneous changes of s and data at the same edge are allowed. The values sampled together at that edge are used.

Test Plan:
- Reset: hold rst=1 for 2 clocks with x1=1, s=0, x2=1 -> f=0 throughout. Release -> f=1 one clock later (PIPE_STAGES=1).
- Truth table, WIDTH=1, PIPE_STAGES=1: apply (x1,s,x2) = 000, 001, 010, 011, 100, 101, 110, 111, one per clock -> f = 0,0,0,1,1,1,0,1, each one clock after its input.
- Back-to-back select toggle: x1=0, x2=1, s alternating 0/1 every clock -> f alternates 0/1 with 1-clock lag. No missed cycles.
- Mid-stream reset: with f=1 steady, assert rst for one edge -> f=0 next cycle. Then f returns to the selected value one clock after release.
- WIDTH=8, PIPE_STAGES=3: x1=8'hA5, x2=8'h3C, s=0 then s=1 -> f=8'hA5 three clocks after first sample, 8'h3C on the following cycle.
- PIPE_STAGES=0: any input change -> f updates combinationally within the same cycle, with rst having no effect.
